// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of digit steps per operation.
  function automatic int calc_n(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter must reach N without wrapping, hence N+1 codes.
  function automatic int calc_cnt_w(input int width, input int digit);
    return $clog2((width / digit) + 1);
  endfunction

  function automatic bit digit_divides(input int width, input int digit);
    return (digit > 0) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  // valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high; a producer holds valid and its data until that edge.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
`endif
endinterface

// File: rtl/serial_adder_adder_digit.sv
// Combinational DIGIT-bit ripple adder used as the single digit slice.
// o_c_msb (carry into the top bit) is present only with SERIAL_ADDER_OVF_EN.
module adder_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_ci,
  output logic [DIGIT-1:0] o_s,
  output logic             o_co
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             o_c_msb
`endif
);
  logic [DIGIT:0] w_c;

  assign w_c[0] = i_ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_co = w_c[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
  assign o_c_msb = w_c[DIGIT-1];
`endif
endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: accepts A, B, cin, adds DIGIT bits per cycle, returns sum/cout.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus,
  output state_t        o_state
);
  localparam int N     = calc_n(WIDTH, DIGIT);
  localparam int CNT_W = calc_cnt_w(WIDTH, DIGIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if ((WIDTH < 2) || !digit_divides(WIDTH, DIGIT)) begin : g_cfg_err
    $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [WIDTH-1:0]       r_a;
  logic [WIDTH-1:0]       r_b;
  logic [WIDTH-1:0]       r_sum;
  logic                   r_carry;
  logic [CNT_W-1:0]       r_cnt;
  logic [DIGIT-1:0]       w_s;
  logic                   w_co;
  logic [WIDTH+DIGIT-1:0] w_sum_cat;
  logic                   w_accept;
  logic                   w_last;
`ifdef SERIAL_ADDER_OVF_EN
  logic                   w_c_msb;
  logic                   r_ovf;
`endif

  assign w_accept  = (r_state == IDLE) && bus.in_valid;
  assign w_last    = (r_state == RUN) && (r_cnt == LAST);
  // New digit enters at the MSB end; after N steps digit 0 sits at the LSB.
  assign w_sum_cat = {w_s, r_sum} >> DIGIT;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus.in_valid)  w_state_nxt = RUN;
      RUN:     if (w_last)        w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    unique case (r_state)
      IDLE:    bus.in_ready  = 1'b1;
      RUN:     bus.busy      = 1'b1;
      DONE: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
      end
      default: bus.in_ready  = 1'b1;
    endcase
  end

  adder_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .i_a     (r_a[DIGIT-1:0]),
    .i_b     (r_b[DIGIT-1:0]),
    .i_ci    (r_carry),
    .o_s     (w_s),
    .o_co    (w_co)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .o_c_msb (w_c_msb)
`endif
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_carry <= bus.cin;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_sum   <= w_sum_cat[WIDTH-1:0];
      r_carry <= w_co;
      r_cnt   <= r_cnt + CNT_W'(1);
`ifdef SERIAL_ADDER_OVF_EN
      if (w_last) r_ovf <= w_c_msb ^ w_co;
`endif
    end
  end

  assign bus.sum  = r_sum;
  assign bus.cout = r_carry;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf  = r_ovf;
`endif
  assign o_state  = r_state;

endmodule
